irq_test_monitor: RTL and testbench
===================================

IRQ_TEST_MONITOR -- requirements
Module: irq_test_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: all state updates on rising edge of clock; reset sampled only on that edge.
REQ-002 Parameter TIMEOUT_CYCLES, default 10000, SHALL set the watchdog limit in clock cycles.
REQ-003 Parameter STATUS_START, default 4'h5, SHALL set the status code that marks test start.
REQ-004 Parameter STATUS_PASS, default 4'hA, SHALL set the status code that marks test pass.
REQ-005 Port: clock  in  1  system clock.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: irq_pin  in  1  asynchronous external interrupt pad (mgmt GPIO 7).
REQ-008 Port: bus_we  in  1  register write strobe, one cycle per write.
REQ-009 Port: bus_addr  in  3  register word address.
REQ-010 Port: bus_wdata  in  32  write data.
REQ-011 Port: bus_rdata  out  32  read data, combinational from bus_addr.
REQ-012 Port: irq_out  out  1  interrupt request to CPU.
REQ-013 Port: status  out  4  status code driven to user pads [35:32].
REQ-014 Port: test_started / test_passed / test_timeout  out  1 each  monitor flags.

Function
REQ-015 Register map SHALL be: 0 STATUS[3:0] RW; 1 IRQ_EN[0] RW; 2 IRQ_PEND[0] read, write-1-to-clear; 3 IRQ_CNT[7:0] RO; 4 CYCLES[31:0] RO; 5 FLAGS {timeout,passed,started} in [2:0] RO; addresses 6-7 read 0, writes ignored.
REQ-016 Unused read bits SHALL be 0; writes to RO registers SHALL be ignored.
REQ-017 A register write SHALL take effect on the clock edge where bus_we=1; new value visible on outputs and bus_rdata the following cycle.
REQ-018 status SHALL equal the STATUS register directly (registered, no extra delay).
REQ-019 irq_pin SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected between sync stage 2 and a third history flop.
REQ-020 A detected rising edge SHALL set IRQ_PEND and increment IRQ_CNT, regardless of IRQ_EN; the set occurs 3 cycles after irq_pin rises (pin stable across edges).
REQ-021 IRQ_CNT SHALL saturate at 255.
REQ-022 If an edge detection and a W1C to IRQ_PEND occur in the same cycle, set SHALL win.
REQ-023 Level-held irq_pin SHALL produce only one edge event; a new event requires the pin to go low then high again.
REQ-024 irq_out SHALL be IRQ_PEND AND IRQ_EN, combinational from the registers.
REQ-025 CYCLES SHALL count clock cycles since reset release, saturating at 2^32-1.
REQ-026 test_started SHALL set (sticky) in the cycle after STATUS becomes STATUS_START.
REQ-027 test_passed SHALL set (sticky) in the cycle after STATUS becomes STATUS_PASS, only if test_started is already 1 and test_timeout is 0.
REQ-028 test_timeout SHALL set (sticky) when CYCLES reaches TIMEOUT_CYCLES and test_passed is 0; once set, test_passed SHALL never set.
REQ-029 STATUS_PASS written before STATUS_START SHALL NOT set test_passed.

Reset
REQ-030 On reset: STATUS=0, IRQ_EN=0, IRQ_PEND=0, IRQ_CNT=0, CYCLES=0, all flags=0, synchronizer and history flops=0; hence status=0, irq_out=0.
REQ-031 Reset asserted mid-operation SHALL clear all state on that edge, including sticky flags and any pending edge in the synchronizer.

Verification
REQ-032 Write STATUS=5, then IRQ_EN=1, raise irq_pin -> IRQ_PEND=1 and irq_out=1 exactly 3 cycles later, IRQ_CNT=1, test_started=1.
REQ-033 With IRQ_PEND=1 write addr 2 data 1 -> IRQ_PEND=0, irq_out=0 next cycle; IRQ_CNT unchanged.
REQ-034 Sequence STATUS=5, irq pulse, STATUS=A before 10000 cycles -> test_passed=1, test_timeout=0, status pad reads 4'hA.
REQ-035 Never write STATUS -> test_timeout=1 when CYCLES=10000; later STATUS=5 then A leaves test_passed=0.
REQ-036 IRQ_EN=0, irq pulse -> IRQ_PEND=1, irq_out=0; then IRQ_EN=1 -> irq_out=1 next cycle; W1C coincident with new edge -> IRQ_PEND stays 1.
REQ-037 Write STATUS=A first, then 5 -> test_started=1, test_passed=0; reset mid-test -> all registers, flags and status return to 0.

Source files
------------

// File: rtl/irq_test_monitor.sv
// irq_test_monitor: register block for an interrupt self-test. Synchronises an
// external interrupt pad, latches and counts its rising edges, gates the pending
// bit onto irq_out, and tracks test start/pass/timeout against a free-running
// cycle counter.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   irq_pin                       asynchronous interrupt pad input
//   bus_we, bus_addr, bus_wdata   single-cycle register write port
//   bus_rdata                     read data, combinational from bus_addr
//   irq_out                       IRQ_PEND & IRQ_EN
//   status                        STATUS register driven to the pads
//   test_started/passed/timeout   sticky monitor flags
module irq_test_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter logic [3:0]  STATUS_START   = 4'h5,
  parameter logic [3:0]  STATUS_PASS    = 4'hA
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        irq_pin,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq_out,
  output logic [3:0]  status,
  output logic        test_started,
  output logic        test_passed,
  output logic        test_timeout
);

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned YW = 32;

  localparam logic [AW-1:0] ADDR_STATUS = AW'(0);
  localparam logic [AW-1:0] ADDR_IRQ_EN = AW'(1);
  localparam logic [AW-1:0] ADDR_PEND   = AW'(2);
  localparam logic [AW-1:0] ADDR_CNT    = AW'(3);
  localparam logic [AW-1:0] ADDR_CYCLES = AW'(4);
  localparam logic [AW-1:0] ADDR_FLAGS  = AW'(5);

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [YW-1:0] CYC_MAX     = '1;
  localparam logic [YW-1:0] TIMEOUT_LIM = YW'(TIMEOUT_CYCLES);

  logic [SW-1:0] status_q;
  logic          irq_en_q;
  logic          irq_pend_q;
  logic [CW-1:0] irq_cnt_q;
  logic [YW-1:0] cycles_q;
  logic          started_q;
  logic          passed_q;
  logic          timeout_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          hist_q;

  logic          wr_status_c;
  logic          wr_irq_en_c;
  logic          pend_clr_c;
  logic          irq_edge_c;
  logic [YW-1:0] cycles_next_c;
  logic          pass_set_c;
  logic          timeout_set_c;

  logic          unused_wdata;
  assign unused_wdata = ^bus_wdata[DW-1:SW];

  // Write decode and next-state terms
  always_comb begin
    wr_status_c   = bus_we && (bus_addr == ADDR_STATUS);
    wr_irq_en_c   = bus_we && (bus_addr == ADDR_IRQ_EN);
    pend_clr_c    = bus_we && (bus_addr == ADDR_PEND) && bus_wdata[0];
    irq_edge_c    = sync2_q && !hist_q;
    cycles_next_c = (cycles_q == CYC_MAX) ? cycles_q : cycles_q + YW'(1);
    pass_set_c    = (status_q == STATUS_PASS) && started_q && !timeout_q;
    // A pass landing on the same edge as the limit wins; timeout is then blocked.
    timeout_set_c = (cycles_next_c >= TIMEOUT_LIM) && !passed_q && !pass_set_c;
  end

  // Register state, synchroniser and monitor flags
  always_ff @(posedge clock) begin
    if (reset) begin
      status_q   <= '0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_cnt_q  <= '0;
      cycles_q   <= '0;
      started_q  <= 1'b0;
      passed_q   <= 1'b0;
      timeout_q  <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      hist_q     <= 1'b0;
    end else begin
      sync1_q  <= irq_pin;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      cycles_q <= cycles_next_c;

      if (wr_status_c) status_q <= bus_wdata[SW-1:0];
      if (wr_irq_en_c) irq_en_q <= bus_wdata[0];

      // Edge set has priority over write-1-to-clear.
      if (irq_edge_c)      irq_pend_q <= 1'b1;
      else if (pend_clr_c) irq_pend_q <= 1'b0;

      if (irq_edge_c && (irq_cnt_q != CNT_MAX)) irq_cnt_q <= irq_cnt_q + CW'(1);

      if (status_q == STATUS_START) started_q <= 1'b1;
      if (pass_set_c)               passed_q  <= 1'b1;
      if (timeout_set_c)            timeout_q <= 1'b1;
    end
  end

  // Read mux
  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      ADDR_STATUS: bus_rdata = DW'(status_q);
      ADDR_IRQ_EN: bus_rdata = DW'(irq_en_q);
      ADDR_PEND:   bus_rdata = DW'(irq_pend_q);
      ADDR_CNT:    bus_rdata = DW'(irq_cnt_q);
      ADDR_CYCLES: bus_rdata = cycles_q;
      ADDR_FLAGS:  bus_rdata = DW'({timeout_q, passed_q, started_q});
      default:     bus_rdata = '0;
    endcase
  end

  assign irq_out      = irq_pend_q && irq_en_q;
  assign status       = status_q;
  assign test_started = started_q;
  assign test_passed  = passed_q;
  assign test_timeout = timeout_q;

endmodule

// File: tb/tb_irq_test_monitor.sv
module tb_irq_test_monitor;

  logic        clock;
  logic        reset;
  logic        irq_pin;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq_out;
  logic [3:0]  status;
  logic        test_started;
  logic        test_passed;
  logic        test_timeout;

  irq_test_monitor dut (
    .clock        (clock),
    .reset        (reset),
    .irq_pin      (irq_pin),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .irq_out      (irq_out),
    .status       (status),
    .test_started (test_started),
    .test_passed  (test_passed),
    .test_timeout (test_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [2:0]  addr;
    logic [31:0] rd;
    logic [7:0]  pins;
  } item_t;

  item_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    id_ctr = 0;

  // Expected pad/flag snapshot: {irq_out, status, timeout, passed, started}
  function automatic logic [7:0] p(input logic irq, input logic [3:0] st,
                                   input logic to, input logic pa, input logic sa);
    return {irq, st, to, pa, sa};
  endfunction

  // Monitor: pops one expectation per cycle and compares against the DUT
  initial begin
    item_t it;
    logic [7:0] act;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {irq_out, status, test_timeout, test_passed, test_started};
        n_chk++;
        if (bus_rdata !== it.rd) begin
          n_fail++;
          $display("FAIL chk%0d rdata[addr %0d]: got %h want %h", it.id, it.addr, bus_rdata, it.rd);
        end
        n_chk++;
        if (act !== it.pins) begin
          n_fail++;
          $display("FAIL chk%0d pins{irq,status,to,pa,st}: got %b want %b", it.id, act, it.pins);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d);
    bus_we    = 1'b1;
    bus_addr  = a;
    bus_wdata = d;
    tick();
    bus_we    = 1'b0;
    bus_wdata = '0;
  endtask

  // Observes the current cycle (sampled at negedge), then advances one clock
  task automatic check(input logic [2:0] a, input logic [31:0] rd, input logic [7:0] pn);
    item_t it;
    bus_addr = a;
    it.id    = id_ctr;
    it.addr  = a;
    it.rd    = rd;
    it.pins  = pn;
    id_ctr++;
    q.push_back(it);
    @(negedge clock);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    irq_pin   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state, cycle counting, unmapped and read-only addresses
    check(3'd4, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd4, 32'd1, p(0, 4'h0, 0, 0, 0));
    check(3'd6, 32'd0, p(0, 4'h0, 0, 0, 0));
    write(3'd6, 32'hFFFF_FFFF);
    write(3'd3, 32'h0000_00FF);
    write(3'd5, 32'h0000_0007);
    write(3'd1, 32'hFFFF_FFFE);
    check(3'd6, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd3, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd5, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd1, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd7, 32'd0, p(0, 4'h0, 0, 0, 0));

    // Start, enable, edge timing
    write(3'd0, 32'h5);
    check(3'd0, 32'h5, p(0, 4'h5, 0, 0, 0));
    check(3'd5, 32'h1, p(0, 4'h5, 0, 0, 1));
    write(3'd1, 32'h1);
    check(3'd1, 32'h1, p(0, 4'h5, 0, 0, 1));
    irq_pin = 1'b1;
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    check(3'd2, 32'h1, p(1, 4'h5, 0, 0, 1));
    check(3'd3, 32'h1, p(1, 4'h5, 0, 0, 1));

    // W1C while pin is held high: no re-trigger
    write(3'd2, 32'h1);
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    check(3'd3, 32'h1, p(0, 4'h5, 0, 0, 1));
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    irq_pin = 1'b0;
    repeat (3) tick();

    // Edge with IRQ_EN=0, then enable
    write(3'd1, 32'h0);
    irq_pin = 1'b1;
    repeat (3) tick();
    check(3'd2, 32'h1, p(0, 4'h5, 0, 0, 1));
    check(3'd3, 32'h2, p(0, 4'h5, 0, 0, 1));
    write(3'd1, 32'h1);
    check(3'd1, 32'h1, p(1, 4'h5, 0, 0, 1));

    // W1C on the same edge as a new detection: set wins
    irq_pin = 1'b0;
    repeat (4) tick();
    irq_pin = 1'b1;
    tick();
    tick();
    write(3'd2, 32'h1);
    check(3'd2, 32'h1, p(1, 4'h5, 0, 0, 1));
    check(3'd3, 32'h3, p(1, 4'h5, 0, 0, 1));
    write(3'd2, 32'h1);
    check(3'd2, 32'h0, p(0, 4'h5, 0, 0, 1));
    irq_pin = 1'b0;

    // Pass
    write(3'd0, 32'hA);
    check(3'd0, 32'hA, p(0, 4'hA, 0, 0, 1));
    check(3'd5, 32'h3, p(0, 4'hA, 0, 1, 1));

    // IRQ_CNT saturation
    for (int i = 0; i < 260; i++) begin
      irq_pin = 1'b1;
      tick();
      irq_pin = 1'b0;
      tick();
    end
    repeat (4) tick();
    check(3'd3, 32'd255, p(1, 4'hA, 0, 1, 1));

    // Reset mid-test with an edge in flight in the synchroniser
    irq_pin = 1'b1;
    tick();
    irq_pin = 1'b0;
    do_reset();
    check(3'd4, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd2, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd2, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd2, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd3, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd0, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd5, 32'd0, p(0, 4'h0, 0, 0, 0));
    check(3'd1, 32'd0, p(0, 4'h0, 0, 0, 0));

    // PASS before START
    write(3'd0, 32'hA);
    tick();
    write(3'd0, 32'h5);
    check(3'd5, 32'h0, p(0, 4'h5, 0, 0, 0));
    check(3'd5, 32'h1, p(0, 4'h5, 0, 0, 1));
    tick();
    check(3'd5, 32'h1, p(0, 4'h5, 0, 0, 1));

    // Timeout with STATUS never written, then late start/pass
    do_reset();
    repeat (9999) tick();
    check(3'd4, 32'd9999,  p(0, 4'h0, 0, 0, 0));
    check(3'd4, 32'd10000, p(0, 4'h0, 1, 0, 0));
    write(3'd0, 32'h5);
    check(3'd5, 32'h4, p(0, 4'h5, 1, 0, 0));
    check(3'd5, 32'h5, p(0, 4'h5, 1, 0, 1));
    write(3'd0, 32'hA);
    check(3'd5, 32'h5, p(0, 4'hA, 1, 0, 1));
    check(3'd5, 32'h5, p(0, 4'hA, 1, 0, 1));

    // Every queued expectation must have been consumed
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
